// File: rtl/traffic_phase_sched_if.sv
// traffic_phase_sched_if: control inputs and light outputs of the intersection scheduler.
interface traffic_phase_sched_if;
  logic en_i, ta_i, tb_i, ped_req_i;
  logic [1:0] la_o, lb_o;
  logic [2:0] phase_o;
  logic walk_o, busy_o;
  modport master(output en_i, ta_i, tb_i, ped_req_i, input la_o, lb_o, phase_o, walk_o, busy_o);
  modport slave(input en_i, ta_i, tb_i, ped_req_i, output la_o, lb_o, phase_o, walk_o, busy_o);
endinterface

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: timed two-road light phase scheduler with min/max green arbitration.
// Define PED_WALK_EN to enable the pedestrian walk phase driven by ped_req_i.
module traffic_phase_sched #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int PED_T = 3,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  traffic_phase_sched_if.slave bus
);
  typedef enum logic [2:0] {OFF, AG, AY, ARA, BG, BY, ARB, PED} state_t;
  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_END = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] R_END = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] P_END = CNT_W'(PED_T - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0] la_q, lb_q;
  logic ped_pend_q, ped_pend_d, from_a_q;
  logic g_min, g_max;
  always_comb begin
    g_min = timer_q >= G_MIN;
    g_max = timer_q >= G_MAX;
    state_d = state_q;
    case (state_q)
      OFF: state_d = bus.en_i ? ARB : OFF;
      AG:  state_d = g_min && (!bus.en_i || ((bus.tb_i || ped_pend_q) && (!bus.ta_i || g_max))) ? AY : AG;
      AY:  state_d = timer_q >= Y_END ? ARA : AY;
      ARA: state_d = timer_q < R_END ? ARA : !bus.en_i ? OFF : ped_pend_q ? PED : BG;
      BG:  state_d = g_min && (!bus.en_i || ((bus.ta_i || ped_pend_q) && (!bus.tb_i || g_max))) ? BY : BG;
      BY:  state_d = timer_q >= Y_END ? ARB : BY;
      ARB: state_d = timer_q < R_END ? ARB : !bus.en_i ? OFF : ped_pend_q ? PED : AG;
      PED: state_d = timer_q < P_END ? PED : !bus.en_i ? OFF : from_a_q ? BG : AG;
    endcase
    timer_d = state_d != state_q ? '0 : &timer_q ? timer_q : timer_q + 1'b1;
`ifdef PED_WALK_EN
    // a request arriving on the PED entry edge survives the clear
    ped_pend_d = (state_d == PED && state_q != PED) ? bus.ped_req_i : ped_pend_q | bus.ped_req_i;
`else
    ped_pend_d = 1'b0;
`endif
  end
`ifdef PED_WALK_EN
  logic walk_q;
  assign bus.walk_o = walk_q;
`else
  logic ped_unused;
  assign ped_unused = bus.ped_req_i;
  assign bus.walk_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OFF;
      timer_q <= '0;
      ped_pend_q <= 1'b0;
      from_a_q <= 1'b0;
      la_q <= 2'b00;
      lb_q <= 2'b00;
`ifdef PED_WALK_EN
      walk_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ped_pend_q <= ped_pend_d;
      if (state_q == ARA || state_q == ARB) from_a_q <= state_q == ARA;
      la_q <= state_d == OFF ? 2'b00 : state_d == AG ? 2'b01 : state_d == AY ? 2'b10 : 2'b11;
      lb_q <= state_d == OFF ? 2'b00 : state_d == BG ? 2'b01 : state_d == BY ? 2'b10 : 2'b11;
`ifdef PED_WALK_EN
      walk_q <= state_d == PED;
`endif
    end
  end
  assign bus.la_o = la_q;
  assign bus.lb_o = lb_q;
  assign bus.phase_o = state_q;
  assign bus.busy_o = state_q != OFF;
endmodule
